// File: rtl/iobus_ctrl.sv
// Bridges the OTTER memory stage to the shared IO bus: posted writes drain
// through a small FIFO ahead of reads, and stalled bus cycles are aborted after TIMEOUT.
module iobus_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CPU_WR,
  input  logic        CPU_RD,
  input  logic [31:0] CPU_ADDR,
  input  logic [31:0] CPU_WDATA,
  output logic [31:0] CPU_RDATA,
  output logic        CPU_STALL,
  output logic        CPU_ERR,
  output logic [31:0] IOBUS_ADDR,
  output logic [31:0] IOBUS_OUT,
  output logic        IOBUS_WR,
  output logic        IOBUS_RD,
  input  logic [31:0] IOBUS_IN,
  input  logic        IOBUS_ACK
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  // IDLE: pick next job | WR: post FIFO head | RD: load in flight | RESP: release stalled load
  typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

  state_t        state;
  logic [31:0]   mem_addr [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] tmo_cnt;
  logic          push;
  logic          pop;
  logic          tmo_hit;
  logic          rd_done;

  assign rd_done   = (state == RESP);
  assign CPU_STALL = (CPU_WR && (count == FULL)) || (CPU_RD && !CPU_WR && !rd_done);
  assign push      = CPU_WR && (count != FULL);
  assign tmo_hit   = (tmo_cnt == TMO_LAST) && !IOBUS_ACK;
  assign pop       = (state == WR) && (IOBUS_ACK || tmo_hit);

  assign IOBUS_ADDR = IOBUS_WR ? mem_addr[rd_ptr] : (IOBUS_RD ? CPU_ADDR : 32'h0);
  assign IOBUS_OUT  = IOBUS_WR ? mem_data[rd_ptr] : 32'h0;

  always_ff @(posedge CLK) begin
    if (RST && push) begin
      mem_addr[wr_ptr] <= CPU_ADDR;
      mem_data[wr_ptr] <= CPU_WDATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      tmo_cnt   <= '0;
      CPU_RDATA <= 32'h0;
      CPU_ERR   <= 1'b0;
      IOBUS_WR  <= 1'b0;
      IOBUS_RD  <= 1'b0;
    end else begin
      CPU_ERR <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;

      case (state)
        IDLE: begin
          // WR/RD are only entered from here, so this is the clear-on-entry
          tmo_cnt <= '0;
          if (count != '0) begin
            state    <= WR;
            IOBUS_WR <= 1'b1;
          end else if (CPU_RD && !CPU_WR) begin
            state    <= RD;
            IOBUS_RD <= 1'b1;
          end
        end
        WR: begin
          if (IOBUS_ACK || tmo_hit) begin
            state    <= IDLE;
            IOBUS_WR <= 1'b0;
            CPU_ERR  <= tmo_hit;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RD: begin
          if (IOBUS_ACK) begin
            CPU_RDATA <= IOBUS_IN;
            state     <= RESP;
            IOBUS_RD  <= 1'b0;
          end else if (tmo_hit) begin
            CPU_RDATA <= 32'hDEADBEEF;
            CPU_ERR   <= 1'b1;
            state     <= RESP;
            IOBUS_RD  <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iobus_ctrl.sv
// Self-checking bench for iobus_ctrl: directed scenarios plus a randomized
// CPU/peripheral mix checked against a queue-based ordering model.
module tb_iobus_ctrl;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_wr, cpu_rd;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall, cpu_err;
  logic [31:0] bus_addr, bus_out, bus_in;
  logic        bus_wr, bus_rd, bus_ack;

  int tests = 0;
  int fails = 0;

  iobus_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .CLK(clk), .RST(rst),
    .CPU_WR(cpu_wr), .CPU_RD(cpu_rd), .CPU_ADDR(cpu_addr), .CPU_WDATA(cpu_wdata),
    .CPU_RDATA(cpu_rdata), .CPU_STALL(cpu_stall), .CPU_ERR(cpu_err),
    .IOBUS_ADDR(bus_addr), .IOBUS_OUT(bus_out), .IOBUS_WR(bus_wr), .IOBUS_RD(bus_rd),
    .IOBUS_IN(bus_in), .IOBUS_ACK(bus_ack)
  );

  always #5 clk = ~clk;

  // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int strobes = 0;
    rst = 1'b0; cpu_wr = 1'b1; cpu_addr = 32'hCAFE_0000; cpu_wdata = 32'h1;
    next_cycle();
    next_cycle();
    rst = 1'b1; cpu_wr = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus_wr, bus_rd, cpu_err, cpu_stall} !== 4'b0)
      $display("FAIL reset_ctl: got wr/rd/err/stall=%b expected 0000", {bus_wr, bus_rd, cpu_err, cpu_stall});
    tests++;
    if (bus_addr !== 32'h0 || bus_out !== 32'h0)
      $display("FAIL reset_bus: got addr=%h out=%h expected 0", bus_addr, bus_out);
    tests++;
    if (cpu_rdata !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", cpu_rdata);
    if (cpu_rdata !== 32'h0 || bus_addr !== 32'h0 || bus_out !== 32'h0 ||
        {bus_wr, bus_rd, cpu_err, cpu_stall} !== 4'b0) fails++;
    next_cycle();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus_wr !== 1'b0) strobes++;
      next_cycle();
    end
    tests++;
    if (strobes != 0) begin
      fails++;
      $display("FAIL reset_no_wr: got %0d bus writes expected 0", strobes);
    end
  endtask

  task automatic test_single_write();
    int  strobes = 0;
    int  strobe_cyc = -1;
    bit  stalled = 1'b0;
    for (int c = 0; c < 8; c++) begin
      cpu_wr    = (c == 0);
      cpu_addr  = (c == 0) ? 32'h1100_0020 : 32'h0;
      cpu_wdata = (c == 0) ? 32'h0000_00A5 : 32'h0;
      bus_ack   = bus_wr;
      @(negedge clk);
      if (cpu_stall) stalled = 1'b1;
      if (bus_wr) begin
        strobes++;
        strobe_cyc = c;
        tests++;
        if (bus_addr !== 32'h1100_0020 || bus_out !== 32'h0000_00A5) begin
          fails++;
          $display("FAIL single_bus: got addr=%h out=%h expected 11000020/000000a5", bus_addr, bus_out);
        end
      end
      next_cycle();
    end
    cpu_wr = 1'b0; bus_ack = 1'b0;
    tests++;
    if (stalled) begin fails++; $display("FAIL single_stall: got stall=1 expected 0"); end
    tests++;
    if (strobes != 1) begin fails++; $display("FAIL single_count: got %0d strobes expected 1", strobes); end
    tests++;
    if (strobe_cyc != 2) begin fails++; $display("FAIL single_latency: got cycle %0d expected 2", strobe_cyc); end
  endtask

  task automatic test_full_fifo();
    logic [31:0] qa[$];
    logic [31:0] qd[$];
    logic [31:0] wd[5];
    int i = 0;
    int acc4 = -1;
    int first_ack = -1;
    for (int k = 0; k < 5; k++) wd[k] = $urandom;
    for (int c = 0; c < 60 && !(i == 5 && qa.size() == 0); c++) begin
      cpu_wr    = (i < 5);
      cpu_addr  = 32'h1100_0100 + 32'(i * 4);
      cpu_wdata = (i < 5) ? wd[i] : 32'h0;
      bus_ack   = bus_wr && (c >= 6);
      @(negedge clk);
      if (c == 4) begin
        tests++;
        if (cpu_stall !== 1'b1) begin fails++; $display("FAIL full_stall: got %b expected 1", cpu_stall); end
      end
      if (bus_wr && bus_ack) begin
        if (first_ack < 0) first_ack = c;
        tests++;
        if (qa.size() == 0) begin
          fails++; $display("FAIL full_order: got write %h with nothing queued expected none", bus_addr);
        end else begin
          if (bus_addr !== qa[0] || bus_out !== qd[0]) begin
            fails++;
            $display("FAIL full_order: got %h/%h expected %h/%h", bus_addr, bus_out, qa[0], qd[0]);
          end
          void'(qa.pop_front()); void'(qd.pop_front());
        end
      end
      if (cpu_wr && !cpu_stall) begin
        qa.push_back(cpu_addr); qd.push_back(cpu_wdata);
        if (i == 4) acc4 = c;
        i++;
      end
      next_cycle();
    end
    cpu_wr = 1'b0; bus_ack = 1'b0;
    tests++;
    if (first_ack != 6) begin fails++; $display("FAIL full_first_ack: got cycle %0d expected 6", first_ack); end
    tests++;
    if (acc4 != 7) begin fails++; $display("FAIL full_accept5: got cycle %0d expected 7", acc4); end
    tests++;
    if (i != 5 || qa.size() != 0) begin
      fails++; $display("FAIL full_drain: got %0d accepted %0d pending expected 5/0", i, qa.size());
    end
  endtask

  task automatic test_read_order();
    int k = 0, run = 0, wr_acks = 0, rd_ack_cyc = -10, retire_cyc = -1;
    bit rd_seen = 1'b0, done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      if (k < 2) begin
        cpu_wr = 1'b1; cpu_rd = 1'b0;
        cpu_addr = 32'h1100_0040 + 32'(k * 4); cpu_wdata = 32'h77 + 32'(k);
      end else begin
        cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_addr = 32'h1100_0000; cpu_wdata = 32'h0;
      end
      run     = (bus_wr || bus_rd) ? run + 1 : 0;
      bus_ack = (run >= 2);
      bus_in  = 32'h1234_5678;
      @(negedge clk);
      if (bus_wr && bus_ack) wr_acks++;
      if (bus_rd && !rd_seen) begin
        rd_seen = 1'b1;
        tests++;
        if (wr_acks != 2) begin fails++; $display("FAIL order_rd_after_wr: got %0d acked writes expected 2", wr_acks); end
        tests++;
        if (bus_addr !== 32'h1100_0000) begin fails++; $display("FAIL order_rd_addr: got %h expected 11000000", bus_addr); end
      end
      if (bus_rd && bus_ack) rd_ack_cyc = c;
      if (k < 2 && !cpu_stall) k++;
      else if (k == 2 && !cpu_stall) begin
        done = 1'b1; retire_cyc = c;
        tests++;
        if (cpu_rdata !== 32'h1234_5678) begin fails++; $display("FAIL order_rdata: got %h expected 12345678", cpu_rdata); end
      end
      next_cycle();
    end
    cpu_rd = 1'b0; bus_ack = 1'b0; bus_in = 32'h0;
    tests++;
    if (!done || retire_cyc != rd_ack_cyc + 1) begin
      fails++; $display("FAIL order_resp: got retire cycle %0d expected %0d", retire_cyc, rd_ack_cyc + 1);
    end
  endtask

  // mode 0: read never acked, 1: read acked in its TIMEOUT-th cycle, 2: write never acked
  task automatic test_timeout();
    for (int mode = 0; mode < 3; mode++) begin
      int hi = 0, errs = 0;
      bit retired = 1'b0;
      logic [31:0] exp = (mode == 0) ? 32'hDEAD_BEEF : 32'h0BAD_F00D;
      for (int c = 0; c < 16; c++) begin
        cpu_rd    = (mode < 2) && !retired;
        cpu_wr    = (mode == 2) && (c == 0);
        cpu_addr  = 32'h1100_0080;
        cpu_wdata = 32'h55;
        bus_ack   = (mode == 1) && bus_rd && (hi == TIMEOUT - 1);
        bus_in    = 32'h0BAD_F00D;
        @(negedge clk);
        if (bus_rd || bus_wr) hi++;
        if (cpu_err) errs++;
        if (mode < 2 && !retired && !cpu_stall) begin
          retired = 1'b1;
          tests++;
          if (cpu_rdata !== exp) begin fails++; $display("FAIL tmo_rdata%0d: got %h expected %h", mode, cpu_rdata, exp); end
          tests++;
          if (cpu_err !== (mode == 0)) begin fails++; $display("FAIL tmo_err_at_resp%0d: got %b expected %b", mode, cpu_err, mode == 0); end
        end
        next_cycle();
      end
      cpu_rd = 1'b0; cpu_wr = 1'b0; bus_ack = 1'b0;
      tests++;
      if (hi != TIMEOUT) begin fails++; $display("FAIL tmo_strobe%0d: got %0d cycles expected %0d", mode, hi, TIMEOUT); end
      tests++;
      if (errs != ((mode == 1) ? 0 : 1)) begin
        fails++; $display("FAIL tmo_err_count%0d: got %0d expected %0d", mode, errs, (mode == 1) ? 0 : 1);
      end
      if (mode < 2) begin
        tests++;
        if (!retired) begin fails++; $display("FAIL tmo_release%0d: got stalled expected released", mode); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int strobes = 0;
    for (int c = 0; c < 4; c++) begin
      cpu_wr = (c < 3); cpu_addr = 32'h1100_0200 + 32'(c * 4); cpu_wdata = 32'(c);
      bus_ack = 1'b0;
      if (c == 3) rst = 1'b0;
      @(negedge clk);
      if (c == 3) begin
        tests++;
        if (bus_wr !== 1'b1) begin fails++; $display("FAIL mid_pre: got wr=%b expected 1", bus_wr); end
      end
      next_cycle();
    end
    rst = 1'b1; cpu_wr = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) begin
        tests++;
        if (bus_wr !== 1'b0) begin fails++; $display("FAIL mid_drop: got wr=%b expected 0", bus_wr); end
      end
      if (bus_wr || cpu_err) strobes++;
      next_cycle();
    end
    tests++;
    if (strobes != 0) begin fails++; $display("FAIL mid_quiet: got %0d bus events expected 0", strobes); end
    strobes = 0;
    for (int c = 0; c < 8; c++) begin
      cpu_wr = (c == 0); cpu_addr = 32'h1100_0300; cpu_wdata = 32'h99;
      bus_ack = bus_wr;
      @(negedge clk);
      if (bus_wr) begin
        strobes++;
        tests++;
        if (bus_addr !== 32'h1100_0300 || bus_out !== 32'h99) begin
          fails++; $display("FAIL mid_new_bus: got %h/%h expected 11000300/00000099", bus_addr, bus_out);
        end
      end
      next_cycle();
    end
    cpu_wr = 1'b0; bus_ack = 1'b0;
    tests++;
    if (strobes != 1) begin fails++; $display("FAIL mid_count: got %0d strobes expected 1", strobes); end
  endtask

  task automatic test_random();
    logic [31:0] qa[$];
    logic [31:0] qd[$];
    logic [31:0] a = 0, d = 0, exp_rd = 0;
    int n = 0, run = 0, rd_ack_cyc = -10;
    bit active = 1'b0, is_rd = 1'b0, both = 1'b0, rd_acked = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (!active && n < 60 && $urandom_range(3) != 0) begin
        active = 1'b1; n++; rd_acked = 1'b0;
        a = 32'h1100_0000 | ($urandom & 32'h0000_0FFC);
        d = $urandom;
        case ($urandom_range(7))
          0, 1, 2: begin is_rd = 1'b1; both = 1'b0; end
          3:       begin is_rd = 1'b0; both = 1'b1; end
          default: begin is_rd = 1'b0; both = 1'b0; end
        endcase
      end
      cpu_wr    = active && !is_rd;
      cpu_rd    = active && (is_rd || both);
      cpu_addr  = active ? a : 32'h0;
      cpu_wdata = active ? d : 32'h0;
      run       = (bus_wr || bus_rd) ? run + 1 : 0;
      bus_ack   = (bus_wr || bus_rd) && (run >= 6 || $urandom_range(1) == 1);
      bus_in    = $urandom;
      @(negedge clk);
      if (cpu_wr) begin
        tests++;
        if (cpu_stall !== (qa.size() == DEPTH)) begin
          fails++; $display("FAIL rand_wr_stall: got %b expected %b (%0d queued)", cpu_stall, qa.size() == DEPTH, qa.size());
        end
      end
      tests++;
      if (cpu_err !== 1'b0) begin fails++; $display("FAIL rand_err: got %b expected 0", cpu_err); end
      if (bus_rd) begin
        tests++;
        if (qa.size() != 0 || bus_addr !== a) begin
          fails++; $display("FAIL rand_rd_issue: got addr %h with %0d writes pending expected %h with 0", bus_addr, qa.size(), a);
        end
      end
      if (bus_wr && bus_ack) begin
        tests++;
        if (qa.size() == 0) begin
          fails++; $display("FAIL rand_wr_order: got write %h expected none pending", bus_addr);
        end else begin
          if (bus_addr !== qa[0] || bus_out !== qd[0]) begin
            fails++; $display("FAIL rand_wr_order: got %h/%h expected %h/%h", bus_addr, bus_out, qa[0], qd[0]);
          end
          void'(qa.pop_front()); void'(qd.pop_front());
        end
      end
      if (bus_rd && bus_ack) begin rd_acked = 1'b1; exp_rd = bus_in; rd_ack_cyc = c; end
      if (active && !cpu_stall) begin
        if (cpu_wr) begin
          qa.push_back(a); qd.push_back(d);
        end else begin
          tests++;
          if (!rd_acked || rd_ack_cyc != c - 1 || cpu_rdata !== exp_rd) begin
            fails++; $display("FAIL rand_rd_data: got %h acked=%0d at %0d expected %h acked at %0d", cpu_rdata, rd_acked, rd_ack_cyc, exp_rd, c - 1);
          end
        end
        active = 1'b0;
      end
      next_cycle();
      if (n == 60 && !active && qa.size() == 0 && !bus_wr && !bus_rd) break;
    end
    cpu_wr = 1'b0; cpu_rd = 1'b0; bus_ack = 1'b0;
    tests++;
    if (n != 60 || active || qa.size() != 0) begin
      fails++; $display("FAIL rand_drain: got %0d ops %0d pending expected 60/0", n, qa.size());
    end
  endtask

  initial begin
    rst = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    bus_in = 32'h0; bus_ack = 1'b0;
    #1;
    test_reset();
    test_single_write();
    test_full_fifo();
    test_read_order();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end

endmodule
